div_iterative: RTL and testbench
================================

Name: div_iterative

Overview:
- Multicycle signed integer divider in the CPU execute stage, beside the ALU.
- Consumes operands from the register-file read latch and produces quotient and remainder for the X/M writeback path.
- Two's-complement negation is done as bitwise inversion plus one.
- One restoring-division step per clock; the pipeline stalls while data_busy is high.

Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits.
- CNT_W, 6: iteration counter width; must hold the value WIDTH.

Ports:
- clock  input  1  single rising-edge clock.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- ctrl_DIV  input  1  start pulse; operands are sampled on the same edge.
- data_operandA  input  WIDTH  signed dividend.
- data_operandB  input  WIDTH  signed divisor.
- data_result  output  WIDTH  signed quotient, registered.
- data_remainder  output  WIDTH  signed remainder; takes the sign of the dividend.
- data_resultRDY  output  1  one-cycle pulse; results are valid while it is high and held afterwards.
- data_exception  output  1  set with data_resultRDY on divide-by-zero or overflow.
- data_busy  output  1  high from the cycle after the start edge until the RDY cycle, inclusive.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, counter=0.
  - data_result=0, data_remainder=0, data_resultRDY=0, data_exception=0, data_busy=0.
  - An in-flight operation is discarded, with no RDY pulse.
- State IDLE:
  - ctrl_DIV high at edge E0: latch |A| and |B| (negation = ~x+1), sign_q = A[msb]^B[msb], sign_r = A[msb].
  - B==0 at E0: go to DONE with flag_dz.
  - Otherwise: A==INT_MIN and B==-1 sets flag_ov, then go to RUN with counter=0 and partial remainder P=0.
- State RUN, one step per edge:
  - {P,Q} shifted left 1.
  - T = P - |B|, computed WIDTH+1 bits wide.
  - If T is non-negative: P=T and Q[0]=1; else Q[0]=0.
  - Counter increments; after step WIDTH (edge E32 for WIDTH=32) go to FIX.
- State FIX, one edge:
  - data_result = sign_q ? ~Q+1 : Q.
  - data_remainder = sign_r ? ~P+1 : P.
  - Go to DONE.
- State DONE, one cycle:
  - data_resultRDY=1; data_exception = flag_dz | flag_ov; next edge returns to IDLE.
- Normal latency: start edge E0, RDY high during the cycle after edge E34 (WIDTH+2 edges).
- Divide-by-zero:
  - RDY high during the cycle after E1.
  - data_result=0, data_remainder=data_operandA, data_exception=1.
- Overflow (INT_MIN / -1):
  - Full latency.
  - data_result=0x80000000, data_remainder=0, data_exception=1.
- Outputs hold their last values until the next start. data_exception clears on the next start edge.
- ctrl_DIV while busy (RUN/FIX/DONE): abort the current operation, relatch operands, restart at counter=0. No RDY pulse for the aborted operation.
- ctrl_DIV held high across multiple cycles: re-triggers each cycle. Upstream must pulse it.
- Reset released mid-cycle: the first start is accepted on the first rising edge with reset high.

Test Plan:
- 100 / 7, start pulse at E0 -> RDY only in the cycle after E34; result=14, remainder=2, exception=0, busy high for exactly 34 cycles.
- Signs: -100/7 -> -14, rem -2; 100/-7 -> -14, rem 2; -100/-7 -> 14, rem -2. Each with exception=0.
- 0x12345678 / 0 -> RDY after E1; result=0, remainder=0x12345678, exception=1. The next start, 9/3, gives 3, rem 0, exception=0.
- 0x80000000 / 0xFFFFFFFF -> result=0x80000000, remainder=0, exception=1. 0x80000000 / 1 -> 0x80000000, exception=0.
- Start 50/5, then ctrl_DIV with 81/9 at E10 -> no RDY for the first operation; RDY after E10+34 with result=9.
- Reset low at E20 of an operation -> all outputs 0 immediately (asynchronous), no RDY. After release, 7/2 -> 3, rem 1.

Source files
------------

// File: rtl/div_iterative.sv
// Multicycle signed restoring divider: one quotient bit per clock, WIDTH+2 edges start-to-ready.
// A new start in any state aborts the operation in flight; divide-by-zero and INT_MIN/-1 raise data_exception.
module div_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic             data_busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dz;
  logic             r_ov;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_remainder;
  logic             r_rdy;
  logic             r_exc;
  logic             r_busy;

  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_b_zero;
  logic             w_ovf;
  logic [WIDTH:0]   w_t;
  logic [WIDTH-1:0] w_p_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;

  assign w_a_abs  = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
  assign w_b_abs  = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
  assign w_b_zero = (data_operandB == '0);
  assign w_ovf    = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);

  // P never exceeds |B|-1 <= 2^(WIDTH-1)-1, so the shifted {P,Q[msb]} fits the WIDTH+1 trial difference.
  assign w_t      = {r_p, r_q[WIDTH-1]} - {1'b0, r_b};
  assign w_p_next = w_t[WIDTH] ? {r_p[WIDTH-2:0], r_q[WIDTH-1]} : w_t[WIDTH-1:0];
  assign w_q_next = {r_q[WIDTH-2:0], ~w_t[WIDTH]};
  assign w_last   = (r_cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (ctrl_DIV) begin
      w_next = w_b_zero ? S_DONE : S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (w_last) w_next = S_FIX;
        S_FIX:   w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_p         <= '0;
      r_q         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dz        <= 1'b0;
      r_ov        <= 1'b0;
      r_result    <= '0;
      r_remainder <= '0;
      r_rdy       <= 1'b0;
      r_exc       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Busy and ready lag the state by one edge, so both cover the DONE->IDLE cycle.
      r_busy <= (r_state != S_IDLE);
      r_rdy  <= 1'b0;
      if (ctrl_DIV) begin
        r_p      <= '0;
        r_q      <= w_a_abs;
        r_b      <= w_b_abs;
        r_cnt    <= '0;
        r_sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_sign_r <= data_operandA[WIDTH-1];
        r_dz     <= w_b_zero;
        r_ov     <= w_ovf;
        r_exc    <= 1'b0;
        if (w_b_zero) begin
          r_result    <= '0;
          r_remainder <= data_operandA;
        end
      end else begin
        case (r_state)
          S_RUN: begin
            r_p   <= w_p_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + CNT_W'(1);
          end
          S_FIX: begin
            r_result    <= r_sign_q ? (~r_q + WIDTH'(1)) : r_q;
            r_remainder <= r_sign_r ? (~r_p + WIDTH'(1)) : r_p;
          end
          S_DONE: begin
            r_rdy <= 1'b1;
            r_exc <= r_dz | r_ov;
          end
          default: ;
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_remainder = r_remainder;
  assign data_resultRDY = r_rdy;
  assign data_exception = r_exc;
  assign data_busy      = r_busy;

endmodule

// File: tb/tb_div_iterative.sv
// Self-checking bench for div_iterative: directed sign/boundary cases, abort, async reset and random ops vs an arithmetic model.
module tb_div_iterative;

  logic        clock;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_resultRDY;
  logic        data_exception;
  logic        data_busy;

  int n_cmp;
  int n_err;

  div_iterative #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .data_busy      (data_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: truncating signed division, with the two exceptional cases handled before any host division.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic e, output int lat);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'd0; r = a; e = 1'b1; lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; e = 1'b1; lat = 34;
    end else begin
      q = sa / sb; r = sa % sb; e = 1'b0; lat = 34;
    end
  endtask

  // Pulses a start at one edge, then counts edges until the ready pulse (bounded).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_n);
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = a; data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
    lat = 0;
    busy_n = data_busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      lat++;
      if (data_busy) busy_n++;
      if (data_resultRDY) break;
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({data_result, data_remainder, data_resultRDY, data_exception, data_busy} !== 67'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got q=%h r=%h rdy=%b exc=%b busy=%b, want all zero",
               data_result, data_remainder, data_resultRDY, data_exception, data_busy);
    end
    @(negedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic test_basic;
    int lat, busy_n;
    do_op(32'd100, 32'd7, lat, busy_n);
    n_cmp++;
    if (lat !== 34) begin n_err++; $display("FAIL basic_latency: got %0d want 34", lat); end
    n_cmp++;
    if (data_result !== 32'd14 || data_remainder !== 32'd2 || data_exception !== 1'b0) begin
      n_err++;
      $display("FAIL basic_value: got q=%0d r=%0d exc=%b want q=14 r=2 exc=0", data_result, data_remainder, data_exception);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (busy_n !== 34) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 34", busy_n); end
    n_cmp++;
    if (data_resultRDY !== 1'b0 || data_busy !== 1'b0 || data_result !== 32'd14 || data_remainder !== 32'd2) begin
      n_err++;
      $display("FAIL basic_hold: got rdy=%b busy=%b q=%0d r=%0d want rdy=0 busy=0 q=14 r=2",
               data_resultRDY, data_busy, data_result, data_remainder);
    end
  endtask

  task automatic test_signs;
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic [31:0] tq [3];
    logic [31:0] tr [3];
    int lat, busy_n;
    ta = '{-32'sd100, 32'sd100, -32'sd100};
    tb = '{32'sd7, -32'sd7, -32'sd7};
    tq = '{-32'sd14, -32'sd14, 32'sd14};
    tr = '{-32'sd2, 32'sd2, -32'sd2};
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], lat, busy_n);
      n_cmp++;
      if (lat !== 34 || data_result !== tq[i] || data_remainder !== tr[i] || data_exception !== 1'b0) begin
        n_err++;
        $display("FAIL signs_%0d: got lat=%0d q=%h r=%h exc=%b want lat=34 q=%h r=%h exc=0",
                 i, lat, data_result, data_remainder, data_exception, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, busy_n;
    do_op(32'h1234_5678, 32'd0, lat, busy_n);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL dz_latency: got %0d want 1", lat); end
    n_cmp++;
    if (data_result !== 32'd0 || data_remainder !== 32'h1234_5678 || data_exception !== 1'b1) begin
      n_err++;
      $display("FAIL dz_value: got q=%h r=%h exc=%b want q=0 r=12345678 exc=1", data_result, data_remainder, data_exception);
    end
    do_op(32'd9, 32'd3, lat, busy_n);
    n_cmp++;
    if (lat !== 34 || data_result !== 32'd3 || data_remainder !== 32'd0 || data_exception !== 1'b0) begin
      n_err++;
      $display("FAIL dz_next: got lat=%0d q=%0d r=%0d exc=%b want lat=34 q=3 r=0 exc=0",
               lat, data_result, data_remainder, data_exception);
    end
  endtask

  task automatic test_overflow;
    int lat, busy_n;
    do_op(32'h8000_0000, 32'hFFFF_FFFF, lat, busy_n);
    n_cmp++;
    if (lat !== 34 || data_result !== 32'h8000_0000 || data_remainder !== 32'd0 || data_exception !== 1'b1) begin
      n_err++;
      $display("FAIL ovf: got lat=%0d q=%h r=%h exc=%b want lat=34 q=80000000 r=0 exc=1",
               lat, data_result, data_remainder, data_exception);
    end
    do_op(32'h8000_0000, 32'd1, lat, busy_n);
    n_cmp++;
    if (lat !== 34 || data_result !== 32'h8000_0000 || data_remainder !== 32'd0 || data_exception !== 1'b0) begin
      n_err++;
      $display("FAIL intmin_by_one: got lat=%0d q=%h r=%h exc=%b want lat=34 q=80000000 r=0 exc=0",
               lat, data_result, data_remainder, data_exception);
    end
  endtask

  task automatic test_abort;
    int lat, busy_n, early;
    early = 0;
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd50; data_operandB = 32'd5;
    @(posedge clock);
    #1 ctrl_DIV = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) early++;
    end
    do_op(32'd81, 32'd9, lat, busy_n);
    n_cmp++;
    if (early !== 0) begin n_err++; $display("FAIL abort_no_rdy: got %0d early pulses want 0", early); end
    n_cmp++;
    if (lat !== 34 || data_result !== 32'd9 || data_remainder !== 32'd0 || data_exception !== 1'b0) begin
      n_err++;
      $display("FAIL abort_result: got lat=%0d q=%0d r=%0d exc=%b want lat=34 q=9 r=0 exc=0",
               lat, data_result, data_remainder, data_exception);
    end
  endtask

  task automatic test_reset_mid;
    int lat, busy_n, pulses;
    pulses = 0;
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd123456; data_operandB = 32'd789;
    @(posedge clock);
    #1 ctrl_DIV = 1'b0;
    repeat (20) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if ({data_result, data_remainder, data_resultRDY, data_exception, data_busy} !== 67'd0) begin
      n_err++;
      $display("FAIL reset_async: got q=%h r=%h rdy=%b exc=%b busy=%b want all zero",
               data_result, data_remainder, data_resultRDY, data_exception, data_busy);
    end
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY || data_busy) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_err++; $display("FAIL reset_discard: got %0d active cycles want 0", pulses); end
    do_op(32'd7, 32'd2, lat, busy_n);
    n_cmp++;
    if (lat !== 34 || data_result !== 32'd3 || data_remainder !== 32'd1 || data_exception !== 1'b0) begin
      n_err++;
      $display("FAIL reset_after: got lat=%0d q=%0d r=%0d exc=%b want lat=34 q=3 r=1 exc=0",
               lat, data_result, data_remainder, data_exception);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, eq, er;
    logic ee;
    int elat, lat, busy_n;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = $urandom_range(1, 50);
        4: begin a = $urandom_range(0, 1000); b = -$urandom_range(1, 40); end
        default: ;
      endcase
      model(a, b, eq, er, ee, elat);
      do_op(a, b, lat, busy_n);
      n_cmp++;
      if (lat !== elat || data_result !== eq || data_remainder !== er || data_exception !== ee) begin
        n_err++;
        $display("FAIL random_%0d: a=%h b=%h got lat=%0d q=%h r=%h exc=%b want lat=%0d q=%h r=%h exc=%b",
                 n, a, b, lat, data_result, data_remainder, data_exception, elat, eq, er, ee);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    test_reset;
    test_basic;
    test_signs;
    test_div_zero;
    test_overflow;
    test_abort;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
